button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Input stage directly upstream of the X/Y sequence-detector FSM. Takes two raw, asynchronous, bouncing
//  pushbuttons and produces clean one-cycle pulses on X and Y that the FSM consumes each CLK.
//  Each channel has a 2-flop synchronizer, a debounce state machine and a registered one-shot.
//  Both channels are identical and independent.
// PARAMETERS
//  DEBOUNCE_CYCLES  1000000  consecutive stable synchronized cycles required to accept a press/release (>=2)
//  REPEAT_DELAY     50000000 cycles from initial pulse to first auto-repeat pulse (AUTO_REPEAT_EN only, >=2)
//  REPEAT_PERIOD    10000000 cycles between subsequent auto-repeat pulses (AUTO_REPEAT_EN only, >=2)
//  Counter widths are $clog2 of the largest count used; no truncation allowed.
// PORTS
//  CLK     in   1  system clock, all logic on rising edge
//  RST     in   1  synchronous, active-high reset
//  BTN_X   in   1  raw pushbutton for X, asynchronous, may bounce
//  BTN_Y   in   1  raw pushbutton for Y, asynchronous, may bounce
//  X       out  1  one-cycle registered pulse per accepted X press (drives FSM .X)
//  Y       out  1  one-cycle registered pulse per accepted Y press (drives FSM .Y)
//  X_LVL   out  1  registered debounced level of BTN_X
//  Y_LVL   out  1  registered debounced level of BTN_Y
// BEHAVIOUR
//  - Reset (sync, RST=1 at edge): sync flops=0, state=IDLE, counters=0, X=Y=X_LVL=Y_LVL=0. Held while RST=1.
//  - Reset mid-operation aborts everything; a button still held after reset is re-debounced and yields a new pulse.
//  - Synchronizer: s1<=BTN, s2<=s1. FSM sees only s2.
//  - Per-channel states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. cnt cleared on every state change.
//    IDLE:         s2=1 -> PRESS_WAIT.
//    PRESS_WAIT:   s2=0 -> IDLE (glitch rejected, no pulse); s2=1 & cnt==DEBOUNCE_CYCLES-1 -> HELD; else cnt++.
//    HELD:         s2=0 -> RELEASE_WAIT.
//    RELEASE_WAIT: s2=1 -> HELD (bounce, no new pulse); s2=0 & cnt==DEBOUNCE_CYCLES-1 -> IDLE; else cnt++.
//  - Pulse is high for exactly one cycle after the PRESS_WAIT->HELD edge. Never asserted on any other transition.
//  - X_LVL/Y_LVL are 1 in HELD and RELEASE_WAIT and 0 otherwise, registered with the state.
//  - Latency: first edge sampling BTN high = edge 1. PRESS_WAIT is entered at edge 3.
//    HELD entry and pulse register at edge DEBOUNCE_CYCLES+3. Release falls X_LVL with the same latency.
//  - Both buttons pressed together: X and Y pulse in the same cycle. No priority and no interaction.
//  - Counters saturate-free by construction: they never exceed DEBOUNCE_CYCLES-1.
// CONFIGURATION
//  AUTO_REPEAT_EN defined:
//    - In HELD a repeat counter runs. Extra one-cycle pulses occur REPEAT_DELAY cycles after the initial pulse.
//    - Further pulses follow every REPEAT_PERIOD cycles while the channel stays in HELD.
//    - Leaving HELD clears the repeat counter.
//    - A RELEASE_WAIT->HELD bounce restarts repeat timing from REPEAT_DELAY, with no pulse on re-entry.
//  AUTO_REPEAT_EN undefined:
//    - Repeat logic and the REPEAT_* counters are absent.
//    - Exactly one pulse per accepted press, regardless of hold time.
// TESTING  (DEBOUNCE_CYCLES=4, 10 ns CLK)
//  1 RST=1 for 3 edges with BTN_X=BTN_Y=1 -> X,Y,X_LVL,Y_LVL stay 0. After RST=0, a pulse 7 edges later.
//  2 BTN_X high 20 cycles, then low -> single X pulse registered at edge 7, X_LVL=1 from edge 7.
//    X_LVL->0 7 edges after the release is sampled. No pulse on release.
//  3 BTN_X 1,1,0,1x12 (bounce), then low -> exactly one X pulse; Y never asserts.
//  4 BTN_Y high 3 cycles only -> Y=0 and Y_LVL=0 throughout (glitch rejected).
//  5 BTN_X and BTN_Y rise on the same edge, held 15 -> X and Y pulse in the same cycle, one each.
//  6 AUTO_REPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=5, BTN_X held 22 cycles -> exactly 3 X pulses.
//    Pulses at edges 7, 17, 22, then none.

Source files
------------

// File: rtl/button_conditioner.sv
// Two-channel pushbutton front end: 2-flop synchronizer, debounce FSM and registered one-shot.
// Define AUTO_REPEAT_EN to add auto-repeat pulses while a button stays held.
module button_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned REPEAT_DELAY    = 50000000,
   parameter int unsigned REPEAT_PERIOD   = 10000000
) (
   input  logic CLK,
   input  logic RST,
   input  logic BTN_X,
   input  logic BTN_Y,
   output logic X,
   output logic Y,
   output logic X_LVL,
   output logic Y_LVL
);

   localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

`ifdef AUTO_REPEAT_EN
   localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RepW = $clog2(RepMax);
   localparam logic [RepW-1:0] RepDelayLast  = RepW'(REPEAT_DELAY - 1);
   localparam logic [RepW-1:0] RepPeriodLast = RepW'(REPEAT_PERIOD - 1);
`endif

   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : gen_bad_param
      $error("button_conditioner: all cycle-count parameters must be >= 2");
   end

   typedef enum logic [1:0] {
      StIdle,
      StPressWait,
      StHeld,
      StReleaseWait
   } state_e;

   logic [1:0] btn;
   logic [1:0] pulse;
   logic [1:0] lvl;

   assign btn = {BTN_Y, BTN_X};

   for (genvar i = 0; i < 2; i++) begin : gen_chan
      logic           s1_q, s2_q;
      state_e         state_q, state_d;
      logic [DbW-1:0] cnt_q, cnt_d;
      logic           pulse_q, pulse_d;
      logic           lvl_q, lvl_d;
`ifdef AUTO_REPEAT_EN
      logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
      logic            rep_first_q, rep_first_d;
`endif

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         pulse_d = 1'b0;
         unique case (state_q)
            StIdle: begin
               if (s2_q) state_d = StPressWait;
            end
            StPressWait: begin
               if (!s2_q) begin
                  state_d = StIdle;
               end else if (cnt_q == DbLast) begin
                  state_d = StHeld;
                  pulse_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + DbW'(1);
               end
            end
            StHeld: begin
               if (!s2_q) state_d = StReleaseWait;
            end
            StReleaseWait: begin
               if (s2_q) begin
                  state_d = StHeld;
               end else if (cnt_q == DbLast) begin
                  state_d = StIdle;
               end else begin
                  cnt_d = cnt_q + DbW'(1);
               end
            end
            default: state_d = StIdle;
         endcase
         if (state_d != state_q) cnt_d = '0;
         lvl_d = (state_d == StHeld) || (state_d == StReleaseWait);
`ifdef AUTO_REPEAT_EN
         rep_cnt_d   = rep_cnt_q;
         rep_first_d = rep_first_q;
         // Any cycle that is not a HELD->HELD stay (re)arms the initial delay.
         if (state_q != StHeld || state_d != StHeld) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
         end else if (rep_cnt_q == (rep_first_q ? RepDelayLast : RepPeriodLast)) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b0;
            pulse_d     = 1'b1;
         end else begin
            rep_cnt_d = rep_cnt_q + RepW'(1);
         end
`endif
      end

      always_ff @(posedge CLK) begin
         if (RST) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            state_q     <= StIdle;
            cnt_q       <= '0;
            pulse_q     <= 1'b0;
            lvl_q       <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
`endif
         end else begin
            s1_q        <= btn[i];
            s2_q        <= s1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pulse_q     <= pulse_d;
            lvl_q       <= lvl_d;
`ifdef AUTO_REPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
`endif
         end
      end

      assign pulse[i] = pulse_q;
      assign lvl[i]   = lvl_q;
   end

   assign X     = pulse[0];
   assign Y     = pulse[1];
   assign X_LVL = lvl[0];
   assign Y_LVL = lvl[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4; edge numbering starts at the
// first edge that samples the button high. Repeat checks apply when AUTO_REPEAT_EN is defined.
module tb_button_conditioner;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic BTN_X = 1'b0;
   logic BTN_Y = 1'b0;
   logic X, Y, X_LVL, Y_LVL;

   int n_checks = 0;
   int n_fail   = 0;

   int edge_n, x_pulses, y_pulses, both_pulses;
   int x_first, y_first, x_lvl_rise, x_lvl_fall;
   logic y_lvl_seen, x_lvl_prev;
   int x_edges[$];

   button_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY   (10),
      .REPEAT_PERIOD  (5)
   ) dut (
      .CLK  (CLK),
      .RST  (RST),
      .BTN_X(BTN_X),
      .BTN_Y(BTN_Y),
      .X    (X),
      .Y    (Y),
      .X_LVL(X_LVL),
      .Y_LVL(Y_LVL)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_stats();
      edge_n      = 0;
      x_pulses    = 0;
      y_pulses    = 0;
      both_pulses = 0;
      x_first     = 0;
      y_first     = 0;
      x_lvl_rise  = 0;
      x_lvl_fall  = 0;
      y_lvl_seen  = 1'b0;
      x_lvl_prev  = X_LVL;
      x_edges.delete();
   endtask

   // Drive buttons for one cycle, then observe outputs 1 ns after the edge.
   task automatic tick(input logic bx, input logic by);
      BTN_X = bx;
      BTN_Y = by;
      @(posedge CLK);
      #1;
      edge_n++;
      if (X === 1'b1) begin
         x_pulses++;
         x_edges.push_back(edge_n);
         if (x_first == 0) x_first = edge_n;
      end
      if (Y === 1'b1) begin
         y_pulses++;
         if (y_first == 0) y_first = edge_n;
      end
      if (X === 1'b1 && Y === 1'b1) both_pulses++;
      if (X_LVL === 1'b1 && x_lvl_rise == 0) x_lvl_rise = edge_n;
      if (x_lvl_prev === 1'b1 && X_LVL === 1'b0) x_lvl_fall = edge_n;
      if (Y_LVL === 1'b1) y_lvl_seen = 1'b1;
      x_lvl_prev = X_LVL;
   endtask

   task automatic settle();
      for (int i = 0; i < 14; i++) tick(1'b0, 1'b0);
      clear_stats();
   endtask

   initial begin
      clear_stats();

      // Reset held with both buttons pressed: everything stays low.
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b1);
         check("rst_outputs", int'({X, Y, X_LVL, Y_LVL}), 0);
      end
      RST = 1'b0;
      clear_stats();
      for (int i = 0; i < 10; i++) tick(1'b1, 1'b1);
      check("post_rst_x_edge", x_first, 7);
      check("post_rst_y_edge", y_first, 7);
      settle();

      // Single clean press.
      for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
      check("press_x_count", x_pulses, 1);
      check("press_x_edge", x_first, 7);
      check("press_lvl_rise", x_lvl_rise, 7);
      check("press_lvl_fall", x_lvl_fall, 27);
      check("press_y_count", y_pulses, 0);
      settle();

      // Bounce on press: edge 3 low restarts the debounce, pulse lands at edge 10.
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      for (int i = 0; i < 12; i++) tick(1'b1, 1'b0);
      for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);
      check("bounce_x_count", x_pulses, 1);
      check("bounce_x_edge", x_first, 10);
      check("bounce_y_count", y_pulses, 0);
      settle();

      // Short glitch on Y is rejected.
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
      for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);
      check("glitch_y_count", y_pulses, 0);
      check("glitch_y_lvl", int'(y_lvl_seen), 0);
      settle();

      // Simultaneous press.
      for (int i = 0; i < 15; i++) tick(1'b1, 1'b1);
      for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);
      check("both_x_count", x_pulses, 1);
      check("both_y_count", y_pulses, 1);
      check("both_same_cycle", both_pulses, 1);
      check("both_y_edge", y_first, 7);
      settle();

      // Long hold: auto-repeat pulses when enabled, otherwise a single pulse.
      for (int i = 0; i < 22; i++) tick(1'b1, 1'b0);
      for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);
`ifdef AUTO_REPEAT_EN
      check("repeat_count", x_pulses, 3);
      if (x_edges.size() == 3) begin
         check("repeat_edge0", x_edges[0], 7);
         check("repeat_edge1", x_edges[1], 17);
         check("repeat_edge2", x_edges[2], 22);
      end
`else
      check("hold_count", x_pulses, 1);
      check("hold_edge", x_first, 7);
`endif
      settle();

      // Reset mid-debounce aborts; the still-held button is re-debounced.
      for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
      RST = 1'b1;
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      check("midrst_outputs", int'({X, Y, X_LVL, Y_LVL}), 0);
      RST = 1'b0;
      clear_stats();
      for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
      check("midrst_x_edge", x_first, 7);
      check("midrst_x_count", x_pulses, 1);
      settle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
